opt_gen: RTL and testbench

Move generator for the replica-exchange TSP annealer. Produces one random tour-modification command (`opt_t`: move type plus city indices K, L) per iteration from a 32-bit xorshift PRNG. Sits directly upstream of each replica and drives its `opt` input. Holds `opt` stable while the replica's distance and exchange stages consume it, and generates the next move on request.

---
 rtl/replica_pkg.sv | 22 ++
 rtl/xorshift32.sv | 37 +++
 rtl/opt_gen.sv | 128 ++++++++++++
 tb/tb_opt_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Shared types and sizing for the replica-exchange TSP annealer.
// Move commands and the packed tour-modification record live here.
package replica_pkg;

  localparam int city_num     = 30;
  localparam int city_num_log = 5;

  // Largest legal city index; city 0 is the fixed tour start.
  localparam logic [city_num_log-1:0] city_max = city_num_log'(city_num - 1);

  typedef enum logic {
    two_opt = 1'b0,
    or_opt  = 1'b1
  } opt_command_t;

  typedef struct packed {
    opt_command_t                command;
    logic [city_num_log-1:0]     k;
    logic [city_num_log-1:0]     l;
  } opt_t;

endpackage

// File: rtl/xorshift32.sv
// 32-bit xorshift PRNG state register (shifts 13/17/5).
// A zero seed, whether from the parameter or a load, is replaced by 1.
module xorshift32 #(
  parameter logic [31:0] SEED = 32'h2545_f491
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        advance,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] r_state;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_step;

  assign w_s1   = r_state ^ (r_state << 13);
  assign w_s2   = w_s1 ^ (w_s1 >> 17);
  assign w_step = w_s2 ^ (w_s2 << 5);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED_NZ;
    end else if (load) begin
      r_state <= (load_data == 32'h0) ? 32'h1 : load_data;
    end else if (advance) begin
      r_state <= w_step;
    end
  end

  assign value = r_state;

endmodule

// File: rtl/opt_gen.sv
// Move generator: draws a random two_opt / or_opt command with cities K, L.
// Define OR_OPT_EN to generate or_opt moves; otherwise every move is two_opt.
module opt_gen
  import replica_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h2545_f491
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_write,
  input  logic [31:0] seed_data,
  input  logic        next,
  output logic        opt_valid,
  output opt_t        opt
);

  typedef enum logic [1:0] {
    GEN_K = 2'd0,
    GEN_L = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [city_num_log-1:0] xs_cand(input logic [31:0] x);
    return city_num_log'(xs_step(x));
  endfunction

`ifdef OR_OPT_EN
  function automatic logic xs_msb(input logic [31:0] x);
    return 1'(xs_step(x) >> 31);
  endfunction
`endif

  state_t                  r_state;
  opt_t                    r_opt;
  logic                    r_opt_valid;

  logic [31:0]             w_prng;
  logic [city_num_log-1:0] w_cand;
  logic                    w_advance;
  logic                    w_in_range;
  logic                    w_l_ok;
  opt_command_t            w_cmd;

  assign w_advance = (r_state == GEN_K) || (r_state == GEN_L);

  xorshift32 #(
    .SEED(SEED)
  ) u_prng (
    .clk       (clk),
    .reset     (reset),
    .load      (seed_write),
    .load_data (seed_data),
    .advance   (w_advance),
    .value     (w_prng)
  );

  // The candidate comes from the value the PRNG advances to this cycle.
  assign w_cand     = xs_cand(w_prng);
  assign w_in_range = (w_cand != '0) && (w_cand <= city_max);

`ifdef OR_OPT_EN
  assign w_cmd  = opt_command_t'(xs_msb(w_prng));
  assign w_l_ok = w_in_range && (w_cand != r_opt.k) &&
                  !((r_opt.command == or_opt) && (w_cand == r_opt.k - 1'b1));
`else
  assign w_cmd  = two_opt;
  assign w_l_ok = w_in_range && (w_cand != r_opt.k);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= GEN_K;
      r_opt       <= '0;
      r_opt_valid <= 1'b0;
    end else if (seed_write) begin
      r_state     <= GEN_K;
      r_opt_valid <= 1'b0;
    end else begin
      case (r_state)
        GEN_K: begin
          if (w_in_range) begin
            r_opt.k       <= w_cand;
            r_opt.command <= w_cmd;
            r_state       <= GEN_L;
          end
        end
        GEN_L: begin
          if (w_l_ok) begin
            r_opt.l <= w_cand;
            r_state <= FIX;
          end
        end
        FIX: begin
          // two_opt segments are always presented with K < L.
          if ((r_opt.command == two_opt) && (r_opt.k > r_opt.l)) begin
            r_opt.k <= r_opt.l;
            r_opt.l <= r_opt.k;
          end
          r_state     <= DONE;
          r_opt_valid <= 1'b1;
        end
        DONE: begin
          if (next) begin
            r_state     <= GEN_K;
            r_opt_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= GEN_K;
          r_opt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign opt_valid = r_opt_valid;
  assign opt       = r_opt;

endmodule

// File: tb/tb_opt_gen.sv
// Scoreboard bench for opt_gen: stimulus queues expected moves and their
// arrival cycle, a monitor pops and checks them when opt_valid rises.
`timescale 1ns/1ps
module tb_opt_gen;
  import replica_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_write;
  logic [31:0] seed_data;
  logic        next;
  logic        opt_valid;
  opt_t        opt;

  opt_gen #(.SEED(32'h1)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_write (seed_write),
    .seed_data  (seed_data),
    .next       (next),
    .opt_valid  (opt_valid),
    .opt        (opt)
  );

  always #5 clk = ~clk;

  typedef struct {
    opt_t move;
    int   due;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] mx;

  logic s_reset = 1'b0, s_seed = 1'b0, s_next = 1'b0, s_valid = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_reset <= reset;
    s_seed  <= seed_write;
    s_next  <= next;
    s_valid <= opt_valid;
  end

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Reference draw: returns the move, advances x, counts PRNG draws.
  function automatic opt_t ref_move(inout logic [31:0] x, output int draws);
    opt_t m;
    int   c;
    bit   ok;
    m = '0;
    draws = 0;
    do begin
      x = ref_step(x);
      draws++;
      c = int'(x[4:0]);
    end while (c < 1 || c > 29);
    m.k = 5'(c);
`ifdef OR_OPT_EN
    m.command = x[31] ? or_opt : two_opt;
`else
    m.command = two_opt;
`endif
    do begin
      x = ref_step(x);
      draws++;
      c = int'(x[4:0]);
      ok = (c >= 1) && (c <= 29) && (c != int'(m.k)) &&
           !((m.command == or_opt) && (c == int'(m.k) - 1));
    end while (!ok);
    m.l = 5'(c);
    if (m.command == two_opt && m.k > m.l) begin
      m.l = m.k;
      m.k = 5'(c);
    end
    return m;
  endfunction

  function automatic bit legal(input opt_t m);
    bit ok;
    ok = (m.k >= 5'd1) && (m.k <= 5'd29) && (m.l >= 5'd1) && (m.l <= 5'd29) && (m.k != m.l);
    if (m.command == two_opt) ok = ok && (m.k < m.l);
    else ok = ok && (m.l != m.k - 5'd1);
`ifndef OR_OPT_EN
    ok = ok && (m.command == two_opt);
`endif
    return ok;
  endfunction

  // gen_start is the cycle count right after the edge that enters GEN_K.
  task automatic push_model(input int gen_start);
    exp_t e;
    int   d;
    e.move = ref_move(mx, d);
    e.due  = gen_start + d + 1;
    exp_q.push_back(e);
  endtask

  // Seed 1: K from 32'h0004_2021 (=1), L rejects 1 then takes 5; three draws.
  task automatic push_hand(input int gen_start);
    exp_t e;
    int   d;
    opt_t discard;
    e.move.command = two_opt;
    e.move.k       = 5'd1;
    e.move.l       = 5'd5;
    e.due          = gen_start + 4;
    exp_q.push_back(e);
    mx = 32'h1;
    discard = ref_move(mx, d);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && opt_valid !== 1'b1; i++) @(negedge clk);
    if (opt_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout cycle=%0d opt_valid=%b required=1", cyc, opt_valid);
      finish_run();
    end
  endtask

  task automatic do_next();
    next = 1'b1;
    push_model(cyc + 1);
    @(negedge clk);
    next = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each rising opt_valid.
  initial begin : monitor
    logic prev_valid;
    opt_t prev_opt;
    exp_t e;
    prev_valid = 1'b0;
    prev_opt   = '0;
    forever begin
      @(negedge clk);
      if (s_reset) begin
        checks++;
        if (opt_valid !== 1'b0 || opt !== opt_t'(0)) begin
          errors++;
          $display("FAIL reset_state valid=%b opt=%h required valid=0 opt=000", opt_valid, opt);
        end
      end else if (s_seed || (s_valid && s_next)) begin
        checks++;
        if (opt_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop cycle=%0d valid=%b required=0", cyc, opt_valid);
        end
      end else if (s_valid) begin
        checks++;
        if (opt_valid !== 1'b1 || opt !== prev_opt) begin
          errors++;
          $display("FAIL hold cycle=%0d valid=%b opt=%h required valid=1 opt=%h",
                   cyc, opt_valid, opt, prev_opt);
        end
      end
      if (opt_valid === 1'b1 && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_move cycle=%0d got=%h required=none", cyc, opt);
        end else begin
          e = exp_q.pop_front();
          if (opt !== e.move) begin
            errors++;
            $display("FAIL move cycle=%0d got=%h required=%h", cyc, opt, e.move);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL latency valid_at=%0d required=%0d", cyc, e.due);
          end
        end
        checks++;
        if (!legal(opt)) begin
          errors++;
          $display("FAIL legality got cmd=%0d k=%0d l=%0d required legal move",
                   opt.command, opt.k, opt.l);
        end
        $display("move cycle=%0d cmd=%0d k=%0d l=%0d", cyc, opt.command, opt.k, opt.l);
      end
      prev_valid = opt_valid;
      prev_opt   = opt;
    end
  end

  initial begin : stimulus
    reset      = 1'b1;
    seed_write = 1'b0;
    seed_data  = 32'h0;
    next       = 1'b0;
    repeat (3) @(negedge clk);

    // First move from SEED=1, with hand-computed value and latency.
    reset = 1'b0;
    push_hand(cyc);
    wait_valid();

    // Idle in DONE: move and PRNG must stay put.
    repeat (50) @(negedge clk);
    do_next();
    wait_valid();

    // Zero seed behaves as seed 1.
    seed_write = 1'b1;
    seed_data  = 32'h0;
    push_hand(cyc + 1);
    @(negedge clk);
    seed_write = 1'b0;
    wait_valid();

    for (int n = 0; n < 10000; n++) begin
      do_next();
      wait_valid();
    end

    // Lone seed_write in DONE, then seed_write with next: same move expected.
    seed_write = 1'b1;
    seed_data  = 32'hDEAD_BEEF;
    mx = 32'hDEAD_BEEF;
    push_model(cyc + 1);
    @(negedge clk);
    seed_write = 1'b0;
    wait_valid();
    do_next();
    wait_valid();
    seed_write = 1'b1;
    next       = 1'b1;
    seed_data  = 32'hDEAD_BEEF;
    mx = 32'hDEAD_BEEF;
    push_model(cyc + 1);
    @(negedge clk);
    seed_write = 1'b0;
    next       = 1'b0;
    wait_valid();

    // next pulse during generation is ignored.
    do_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    wait_valid();

    // seed_write aborts a move in progress.
    do_next();
    void'(exp_q.pop_back());
    seed_write = 1'b1;
    seed_data  = 32'h1234_5678;
    mx = 32'h1234_5678;
    push_model(cyc + 1);
    @(negedge clk);
    seed_write = 1'b0;
    wait_valid();

    // reset beats a simultaneous seed_write mid-generation.
    do_next();
    void'(exp_q.pop_back());
    reset      = 1'b1;
    seed_write = 1'b1;
    seed_data  = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    seed_write = 1'b0;
    push_hand(cyc);
    wait_valid();
    for (int n = 0; n < 5; n++) begin
      do_next();
      wait_valid();
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    finish_run();
  end

endmodule
